// File: rtl/pulse_conv_pkg.sv
// Shared definitions for the pulse shortener/stretcher family.
package pulse_conv_pkg;

  // Default counter width shared by the shortener and stretcher.
  localparam int unsigned LEN_BITS_DEF = 8;

  // Gap counter width; holds MIN_GAP-1 for MIN_GAP in 1..15.
  localparam int unsigned GAP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_GAP     = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_stretching_device_rise_edge_detect.sv
// Rising-edge detector: trig_o is high for the cycle in which sig_i is 1
// and was 0 on the previous clock. The history flop resets to RST_VAL so a
// level already high at reset release can be masked until it drops.
module rise_edge_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic trig_o
);

  logic prev_q;

  // Remember last cycle's input level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= RST_VAL;
    else         prev_q <= sig_i;
  end

  assign trig_o = sig_i & ~prev_q;

endmodule

// File: rtl/pulse_stretching_device.sv
// Pulse stretcher: turns a rising edge on IN_PULSE into a registered pulse
// of IN_LENGTH clocks, optionally retriggerable, followed by a guaranteed
// MIN_GAP-clock low gap. Triggers that cannot be honoured raise OUT_MISSED
// for one clock. MIN_GAP must lie in 1..15.
module pulse_stretching_device
  import pulse_conv_pkg::*;
#(
  parameter int unsigned LEN_BITS = LEN_BITS_DEF,
  parameter int unsigned MIN_GAP  = 1
) (
  input  logic                IN_CLOCK,
  input  logic                IN_RESET_N,
  input  logic                IN_PULSE,
  input  logic [LEN_BITS-1:0] IN_LENGTH,
  input  logic                IN_RETRIGGER,
  output logic                OUT_LONG_PULSE,
  output logic                OUT_BUSY,
  output logic                OUT_MISSED
);

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);

  state_e              state_q, state_d;
  logic [LEN_BITS-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                pulse_q, pulse_d;
  logic                busy_q, busy_d;
  logic                missed_q, missed_d;

  logic                trig;
  logic                len_nz;
  logic [LEN_BITS-1:0] len_m1;

  // History resets high: a level held across reset release is not a trigger.
  rise_edge_detect #(
    .RST_VAL (1'b1)
  ) u_edge (
    .clk_i  (IN_CLOCK),
    .rst_ni (IN_RESET_N),
    .sig_i  (IN_PULSE),
    .trig_o (trig)
  );

  assign len_nz = (IN_LENGTH != '0);
  assign len_m1 = IN_LENGTH - LEN_BITS'(1);

  // Next-state, counter and output decode; all outputs are then registered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    pulse_d  = pulse_q;
    busy_d   = busy_q;
    missed_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A zero-length trigger in IDLE is silently ignored.
        if (trig && len_nz) begin
          state_d = ST_STRETCH;
          cnt_d   = len_m1;
          pulse_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      ST_STRETCH: begin
        // Retrigger wins even on the final stretch cycle (cnt_q == 0).
        if (trig && IN_RETRIGGER && len_nz) begin
          cnt_d = len_m1;
        end else begin
          if (trig) missed_d = 1'b1;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - LEN_BITS'(1);
          end else begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
            pulse_d = 1'b0;
          end
        end
      end

      ST_GAP: begin
        if (trig) missed_d = 1'b1;
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        pulse_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters and output flops; reset may hit mid-pulse.
  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      gap_q    <= '0;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      pulse_q  <= pulse_d;
      busy_q   <= busy_d;
      missed_q <= missed_d;
    end
  end

  assign OUT_LONG_PULSE = pulse_q;
  assign OUT_BUSY       = busy_q;
  assign OUT_MISSED     = missed_q;

endmodule

// File: tb/tb_pulse_stretching_device.sv
// Directed bench for pulse_stretching_device (LEN_BITS=8, MIN_GAP=1).
module tb_pulse_stretching_device;

  logic       clk;
  logic       rst_n;
  logic       pulse;
  logic [7:0] len;
  logic       retrig;
  logic       out_p;
  logic       out_b;
  logic       out_m;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic  p;
    logic  b;
    logic  m;
    string tag;
  } exp_t;

  exp_t sb[$];

  pulse_stretching_device #(
    .LEN_BITS (8),
    .MIN_GAP  (1)
  ) dut (
    .IN_CLOCK       (clk),
    .IN_RESET_N     (rst_n),
    .IN_PULSE       (pulse),
    .IN_LENGTH      (len),
    .IN_RETRIGGER   (retrig),
    .OUT_LONG_PULSE (out_p),
    .OUT_BUSY       (out_b),
    .OUT_MISSED     (out_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic push(input logic ep, input logic eb, input logic em, input string tag);
    exp_t e;
    e.p = ep; e.b = eb; e.m = em; e.tag = tag;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it against the current outputs.
  task automatic pop_check();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed size=%0d expected >0", sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (out_p === e.p) else begin
        errors++;
        $error("FAIL %s OUT_LONG_PULSE observed=%b expected=%b", e.tag, out_p, e.p);
      end
      checks++;
      assert (out_b === e.b) else begin
        errors++;
        $error("FAIL %s OUT_BUSY observed=%b expected=%b", e.tag, out_b, e.b);
      end
      checks++;
      assert (out_m === e.m) else begin
        errors++;
        $error("FAIL %s OUT_MISSED observed=%b expected=%b", e.tag, out_m, e.m);
      end
    end
  endtask

  // One clock: drive inputs, record what must appear after the edge, sample at edge+1.
  task automatic cyc(input logic ip, input logic [7:0] il, input logic ir,
                     input logic ep, input logic eb, input logic em, input string tag);
    pulse  = ip;
    len    = il;
    retrig = ir;
    push(ep, eb, em, tag);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    rst_n  = 1'b0;
    pulse  = 1'b1;
    len    = 8'd5;
    retrig = 1'b0;

    // Reset state, IN_PULSE already high.
    repeat (2) @(posedge clk);
    #1;
    push(1'b0, 1'b0, 1'b0, "reset_state");
    pop_check();
    rst_n = 1'b1;

    // 1: level held across reset release must not trigger.
    repeat (3) cyc(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, "t1_held_hi");
    cyc(1'b0, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, "t1_low");
    cyc(1'b1, 8'd5, 1'b0, 1'b1, 1'b1, 1'b0, "t1_trig");
    repeat (4) cyc(1'b0, 8'd5, 1'b0, 1'b1, 1'b1, 1'b0, "t1_high");
    cyc(1'b0, 8'd5, 1'b0, 1'b0, 1'b1, 1'b0, "t1_gap");
    cyc(1'b0, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, "t1_idle");

    // 2: a 20-clock level is a single trigger, length 3.
    cyc(1'b1, 8'd3, 1'b0, 1'b1, 1'b1, 1'b0, "t2_trig");
    repeat (2) cyc(1'b1, 8'd3, 1'b0, 1'b1, 1'b1, 1'b0, "t2_high");
    cyc(1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, "t2_gap");
    repeat (16) cyc(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, "t2_level");
    cyc(1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, "t2_release");

    // 3: retrigger 4 clocks in extends to 4+6 = 10 clocks.
    cyc(1'b1, 8'd6, 1'b1, 1'b1, 1'b1, 1'b0, "t3_trig");
    repeat (3) cyc(1'b0, 8'd6, 1'b1, 1'b1, 1'b1, 1'b0, "t3_high_a");
    cyc(1'b1, 8'd6, 1'b1, 1'b1, 1'b1, 1'b0, "t3_retrig");
    repeat (5) cyc(1'b0, 8'd6, 1'b1, 1'b1, 1'b1, 1'b0, "t3_high_b");
    cyc(1'b0, 8'd6, 1'b1, 1'b0, 1'b1, 1'b0, "t3_gap");
    cyc(1'b0, 8'd6, 1'b1, 1'b0, 1'b0, 1'b0, "t3_idle");

    // 4: retrigger disabled -> missed flag; trigger in GAP also missed.
    cyc(1'b1, 8'd6, 1'b0, 1'b1, 1'b1, 1'b0, "t4_trig");
    repeat (3) cyc(1'b0, 8'd6, 1'b0, 1'b1, 1'b1, 1'b0, "t4_high_a");
    cyc(1'b1, 8'd6, 1'b0, 1'b1, 1'b1, 1'b1, "t4_drop");
    cyc(1'b0, 8'd6, 1'b0, 1'b1, 1'b1, 1'b0, "t4_high_b");
    cyc(1'b0, 8'd6, 1'b0, 1'b0, 1'b1, 1'b0, "t4_gap");
    cyc(1'b1, 8'd6, 1'b0, 1'b0, 1'b0, 1'b1, "t4_gap_trig");
    repeat (2) cyc(1'b0, 8'd6, 1'b0, 1'b0, 1'b0, 1'b0, "t4_idle");

    // Retrigger on the last stretch cycle reloads the counter.
    cyc(1'b1, 8'd2, 1'b1, 1'b1, 1'b1, 1'b0, "rl_trig");
    cyc(1'b0, 8'd2, 1'b1, 1'b1, 1'b1, 1'b0, "rl_high_a");
    cyc(1'b1, 8'd3, 1'b1, 1'b1, 1'b1, 1'b0, "rl_retrig_last");
    repeat (2) cyc(1'b0, 8'd3, 1'b1, 1'b1, 1'b1, 1'b0, "rl_high_b");
    cyc(1'b0, 8'd3, 1'b1, 1'b0, 1'b1, 1'b0, "rl_gap");
    cyc(1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, "rl_idle");

    // Zero-length trigger during STRETCH is dropped even with retrigger on.
    cyc(1'b1, 8'd3, 1'b1, 1'b1, 1'b1, 1'b0, "z_trig");
    cyc(1'b0, 8'd3, 1'b1, 1'b1, 1'b1, 1'b0, "z_high_a");
    cyc(1'b1, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, "z_drop");
    cyc(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, "z_gap");
    cyc(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, "z_idle");

    // 5: zero length in IDLE ignored; maximum length 255.
    cyc(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "t5_len0");
    repeat (2) cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "t5_len0_after");
    cyc(1'b1, 8'd255, 1'b0, 1'b1, 1'b1, 1'b0, "t5_max_trig");
    repeat (254) cyc(1'b0, 8'd255, 1'b0, 1'b1, 1'b1, 1'b0, "t5_max_high");
    cyc(1'b0, 8'd255, 1'b0, 1'b0, 1'b1, 1'b0, "t5_max_gap");
    cyc(1'b0, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0, "t5_max_idle");

    // 6: asynchronous reset at clock 3 of a 10-clock pulse.
    cyc(1'b1, 8'd10, 1'b0, 1'b1, 1'b1, 1'b0, "t6_trig");
    repeat (2) cyc(1'b0, 8'd10, 1'b0, 1'b1, 1'b1, 1'b0, "t6_high");
    #2;
    rst_n = 1'b0;
    #1;
    push(1'b0, 1'b0, 1'b0, "t6_async_drop");
    pop_check();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (2) cyc(1'b0, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0, "t6_post_idle");
    cyc(1'b1, 8'd10, 1'b0, 1'b1, 1'b1, 1'b0, "t6_trig2");
    repeat (9) cyc(1'b0, 8'd10, 1'b0, 1'b1, 1'b1, 1'b0, "t6_high2");
    cyc(1'b0, 8'd10, 1'b0, 1'b0, 1'b1, 1'b0, "t6_gap2");
    cyc(1'b0, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0, "t6_idle2");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed size=%0d expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_stretching_device.md
Name: pulse_stretching_device

Overview:
- Counterpart of the rising-edge pulse shortener: converts a rising edge on IN_PULSE (typically a 1-clock pulse from the shortener) into an output pulse of programmable length in clocks.
- Sits after pulse-shortened event sources and drives consumers that need a minimum pulse width (LEDs, slow peripherals, cross-domain handoff).
- Optional retrigger extends an active pulse. A guaranteed low gap follows every pulse. Dropped triggers are flagged.

Parameters:
- LEN_BITS, 8: width of IN_LENGTH and of the internal down-counter.
- MIN_GAP, 1: number of clocks OUT_LONG_PULSE is held low after every pulse. Legal range is 1 to 15.

Ports:
- IN_CLOCK  input  1  single clock; all logic is on its rising edge.
- IN_RESET_N  input  1  asynchronous, active-low reset.
- IN_PULSE  input  1  trigger, synchronous to IN_CLOCK; only its rising edge is significant.
- IN_LENGTH  input  LEN_BITS  pulse length in clocks; sampled on the trigger cycle.
- IN_RETRIGGER  input  1  1 = a trigger while stretching reloads the counter; 0 = that trigger is dropped.
- OUT_LONG_PULSE  output  1  stretched pulse, registered.
- OUT_BUSY  output  1  high in STRETCH and GAP states, registered.
- OUT_MISSED  output  1  1-clock flag marking a trigger that was dropped, registered.

Behaviour:
- Reset (asynchronous assert, any time, including mid-pulse):
  - OUT_LONG_PULSE=0, OUT_BUSY=0, OUT_MISSED=0, state=IDLE, counter=0.
  - Edge-detect register is set to 1, so IN_PULSE held high across reset release does NOT trigger; it must go low first.
- Edge detect:
  - prev <= IN_PULSE every clock.
  - trig = IN_PULSE & ~prev.
  - A level held high for N clocks is one trigger.
- States: IDLE, STRETCH, GAP.
- IDLE:
  - trig with IN_LENGTH != 0 -> STRETCH. counter <= IN_LENGTH-1; OUT_LONG_PULSE <= 1; OUT_BUSY <= 1.
  - trig with IN_LENGTH == 0 -> ignored. Stay IDLE; OUT_MISSED stays 0.
- Latency: trig sampled at edge k gives OUT_LONG_PULSE high for edges k+1 through k+IN_LENGTH inclusive, i.e. exactly IN_LENGTH clocks.
- STRETCH:
  - No trig, counter != 0 -> counter decrements.
  - No trig, counter == 0 -> GAP. gap counter <= MIN_GAP-1; OUT_LONG_PULSE <= 0; OUT_BUSY stays 1.
  - trig with IN_RETRIGGER=1 and IN_LENGTH != 0 -> counter <= IN_LENGTH-1. Output stays high for IN_LENGTH more clocks counted from the retrigger edge. This applies on every STRETCH cycle, including the last one.
  - trig with IN_RETRIGGER=0, or with IN_LENGTH == 0 -> OUT_MISSED=1 for one clock. The pulse is unaffected.
- GAP:
  - Gap counter decrements; on 0 -> IDLE and OUT_BUSY <= 0.
  - Any trig during GAP -> OUT_MISSED=1 for one clock; the trigger is dropped.
- Consecutive pulses from IDLE are therefore separated by at least MIN_GAP low clocks.
- Arithmetic:
  - Counter is unsigned, LEN_BITS wide; no wrap in normal flow, because decrement happens only when counter != 0.
  - IN_LENGTH = 2^LEN_BITS-1 gives the maximum pulse (255 clocks at the default).
- Output timing: all outputs come straight from flops; there are no combinational paths from input to output.
- Changes to IN_LENGTH or IN_RETRIGGER outside a trigger cycle have no effect.

Decomposition:
- Shared package pulse_conv_pkg:
  - state encoding constants ST_IDLE, ST_STRETCH, ST_GAP (2 bits);
  - LEN_BITS default constant, so the shortener/stretcher family agrees on widths.
- One natural sub-module: rise_edge_detect.
  - Contains the prev register, whose reset value is a parameter (1 here), and produces the trig output.
  - Reusable by the shortener rewrite.
- The FSM and counters stay in the top module.

Test Plan:
1. Reset release with IN_PULSE=1 held -> no output. Then IN_PULSE 0 for 1 clk, 1 for 1 clk, IN_LENGTH=5 -> OUT_LONG_PULSE high exactly 5 clks starting one clock after the trigger edge; OUT_BUSY high 6 clks (MIN_GAP=1).
2. IN_PULSE held high 20 clks, IN_LENGTH=3 -> single 3-clk output; OUT_MISSED never asserts.
3. IN_LENGTH=6, IN_RETRIGGER=1, second trigger 4 clks after the first with IN_LENGTH=6 -> output continuous for 4+6=10 clks; OUT_MISSED=0.
4. Same as 3 with IN_RETRIGGER=0 -> output 6 clks; OUT_MISSED one clk, aligned to the second trigger +1. A trigger in the GAP clock -> OUT_MISSED=1 and no new pulse.
5. IN_LENGTH=0 trigger in IDLE -> no output, no busy, no missed. IN_LENGTH=255 -> exactly 255 clks high.
6. IN_RESET_N pulsed low at clock 3 of a 10-clk pulse -> OUT_LONG_PULSE and OUT_BUSY drop asynchronously (before the next edge). After release the block is idle and the next trigger gives a full-length pulse.
